adder64_rr_sched: RTL and testbench
===================================

// Module: adder64_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one adder64 instance among NREQ requesters.
//  - Each cycle it grants at most one pending request and drives that request's
//    operands onto the shared adder.
//  - It captures sum/carry into a single registered response slot and returns
//    the result tagged with the requester ID.
//  - Sits between the issue logic of several execution lanes and the single
//    adder64 datapath (the adder is instantiated outside this block).
// PARAMETERS
//  NREQ   4   number of requesters (2..16)
//  WIDTH  64  operand width; must match the attached adder
//  IDW    $clog2(NREQ)  derived; width of requester ID (localparam)
// PORTS
//  clk          in   1           clock, all logic rising-edge
//  rst          in   1           synchronous reset, active-high
//  req_valid    in   NREQ        per-requester request valid
//  req_ready    out  NREQ        per-requester accept (one-hot or zero)
//  req_op1      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_op2      in   NREQ*WIDTH  operand B, same packing
//  req_cin      in   NREQ        carry-in per requester
//  add_op1      out  WIDTH       to adder op1
//  add_op2      out  WIDTH       to adder op2
//  add_cin      out  1           to adder carry_in
//  add_result   in   WIDTH       from adder result (combinational)
//  add_cout     in   1           from adder carry_out
//  rsp_valid    out  1           response slot holds a result
//  rsp_ready    in   1           consumer accepts response
//  rsp_id       out  IDW         requester index that produced the result
//  rsp_result   out  WIDTH       registered sum
//  rsp_cout     out  1           registered carry-out
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, RR pointer=0.
//  - req_ready=0 while rst is high.
//  Slot:
//  - Single-entry registered slot with states EMPTY / FULL.
//  - can_issue = !rsp_valid | rsp_ready.
//  Grant:
//  - When can_issue, pick the first i with req_valid[i], searching from
//    ptr, ptr+1, ... wrapping modulo NREQ.
//  - req_ready[i]=1 only for the granted i; a handshake occurs when
//    req_valid[i] & req_ready[i].
//  - req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready.
//  - req_ready must not depend on other requesters' data.
//  Adder drive:
//  - add_op1/add_op2/add_cin carry the granted requester's operands.
//  - When nothing is granted, they carry requester ptr's operands (don't-care,
//    stable).
//  Capture:
//  - On a handshake, at the next edge: rsp_result<=add_result,
//    rsp_cout<=add_cout, rsp_id<=i, rsp_valid<=1, ptr<=(i+1) mod NREQ.
//  - Latency is 1 cycle, request handshake to rsp_valid.
//  Drain:
//  - rsp_valid & rsp_ready with no new grant gives rsp_valid<=0.
//  - Simultaneous drain and grant replaces the slot, so rsp_valid stays 1.
//  - This sustains 1 result per cycle.
//  Backpressure:
//  - rsp_valid=1 & rsp_ready=0 forces all req_ready=0.
//  - The slot contents and ptr hold unchanged.
//  Pointer:
//  - ptr changes only on a grant.
//  - With no grant, ptr holds, so an idle cycle does not rotate priority.
//  Fairness:
//  - A continuously valid requester is granted within NREQ grants.
//  Requester contract:
//  - Operands must be stable while req_valid=1 and not yet accepted.
//  Arithmetic:
//  - Pure pass-through of adder output. No truncation or extension
//    (WIDTH bits plus carry).
//  Reset mid-operation:
//  - A pending result in the slot is discarded.
//  - The grant in the reset cycle does not complete.
// TESTING
//  1 Single req:
//    - Stimulus: req_valid=4'b0001, op1=64'hFFFF_FFFF_FFFF_FFFF, op2=1, cin=0.
//    - Response: next cycle rsp_valid=1, rsp_id=0, rsp_result=0, rsp_cout=1.
//  2 All 4 valid every cycle, rsp_ready=1:
//    - Grants go 0,1,2,3,0.
//    - rsp_valid stays high for 4 consecutive cycles.
//    - Results match op1+op2+cin per ID.
//  3 Backpressure:
//    - Stimulus: hold rsp_ready=0 for 3 cycles with req 2 pending.
//    - Response: req_ready=0, rsp_result held.
//    - Release: drain and grant of req 2 occur in the same cycle.
//  4 Carry chain:
//    - Stimulus: op1=64'h7FFF_FFFF_FFFF_FFFF, op2=0, cin=1.
//    - Response: rsp_result=64'h8000_0000_0000_0000, rsp_cout=0.
//  5 Wrap/idle:
//    - Stimulus: grant req 3, then idle 2 cycles, then req 1 and req 3 valid.
//    - Response: ptr=0 after the req 3 grant, so req 1 is granted first.
//  6 Reset mid-op:
//    - Stimulus: assert rst while rsp_valid=1.
//    - Response: rsp_valid=0 and ptr=0 next cycle; no req_ready during reset.

Source files
------------

// File: rtl/adder64_rr_sched.sv
// Round-robin arbiter sharing one external adder among NREQ requesters,
// with a single-entry registered response slot.
module adder64_rr_sched #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_op1,
  output logic [WIDTH-1:0]      add_op2,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_result,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_cout
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e          state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] next_ptr;
  logic           grant_any;
  logic           can_issue;
  logic           handshake;

  assign rsp_valid = (state == FULL);
  assign can_issue = (state == EMPTY) || rsp_ready;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin : rr_search
    grant_any = 1'b0;
    grant_idx = ptr;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign handshake = grant_any && can_issue && !rst;
  assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;

  // Idle adder inputs follow ptr so they stay stable between grants.
  assign sel_idx  = (grant_any && can_issue) ? grant_idx : ptr;
  assign add_op1  = req_op1[sel_idx*WIDTH +: WIDTH];
  assign add_op2  = req_op2[sel_idx*WIDTH +: WIDTH];
  assign add_cin  = req_cin[sel_idx];
  assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Response slot: capture on grant, drain on consumer accept, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else if (handshake) begin
      state      <= FULL;
      ptr        <= next_ptr;
      rsp_id     <= grant_idx;
      rsp_result <= add_result;
      rsp_cout   <= add_cout;
    end else if (state == FULL && rsp_ready) begin
      state      <= EMPTY;
    end
  end

endmodule

// File: tb/tb_adder64_rr_sched.sv
// Bench for adder64_rr_sched: directed scenarios plus a randomized run against
// a queue-free arbitration/sum model of the scheduler.
module tb_adder64_rr_sched;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_op1;
  logic [NREQ*WIDTH-1:0] req_op2;
  logic [NREQ-1:0]       req_cin;
  logic [WIDTH-1:0]      add_op1;
  logic [WIDTH-1:0]      add_op2;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_result;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_cout;

  logic [WIDTH-1:0] op1 [NREQ];
  logic [WIDTH-1:0] op2 [NREQ];

  int n_cmp = 0;
  int n_err = 0;

  // Model of the scheduler's architectural state
  int           m_ptr;
  bit           m_valid;
  int           m_id;
  logic [WIDTH:0] m_sum;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_op1[g*WIDTH +: WIDTH] = op1[g];
    assign req_op2[g*WIDTH +: WIDTH] = op2[g];
  end

  // The external adder this block is attached to
  assign {add_cout, add_result} = {1'b0, add_op1} + {1'b0, add_op2} + (WIDTH+1)'(add_cin);

  adder64_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_cin(req_cin),
    .add_op1(add_op1), .add_op2(add_op2), .add_cin(add_cin),
    .add_result(add_result), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout)
  );

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    if (rst) return '0;
    if (m_valid && !rsp_ready) return '0;
    g = exp_grant();
    if (g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick(output int acc);
    int g;
    bit can;
    can = !m_valid || rsp_ready;
    g   = exp_grant();
    acc = (!rst && can && g >= 0) ? g : -1;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_id = 0; m_sum = '0;
    end else if (acc >= 0) begin
      m_valid = 1;
      m_id    = acc;
      m_sum   = {1'b0, op1[acc]} + {1'b0, op2[acc]} + (WIDTH+1)'(req_cin[acc]);
      m_ptr   = (acc + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    int acc;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    tick(acc);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int acc;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin op1[i] = WIDTH'(i + 5); op2[i] = WIDTH'(i); end
    req_cin = '0;
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tick(acc); tick(acc);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !== '0) begin
      n_err++; $display("FAIL reset_rsp: got v=%b id=%0d r=%h c=%b want all zero",
                        rsp_valid, rsp_id, rsp_result, rsp_cout);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL reset_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick(acc);
  endtask

  task automatic test_single();
    int acc;
    do_reset();
    op1[0] = 64'hFFFF_FFFF_FFFF_FFFF; op2[0] = 64'd1; req_cin = '0;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick(acc);
    req_valid = '0;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !== {1'b1, 2'd0, 64'd0, 1'b1}) begin
      n_err++; $display("FAIL single_rsp: got v=%b id=%0d r=%h c=%b want v=1 id=0 r=0 c=1",
                        rsp_valid, rsp_id, rsp_result, rsp_cout);
    end
    tick(acc);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int acc;
    int run;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op1[i] = {$urandom, $urandom}; op2[i] = {$urandom, $urandom};
    end
    req_cin = 4'($urandom); req_valid = '1; rsp_ready = 1'b1; run = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== (NREQ'(1) << (k % NREQ))) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, NREQ'(1) << (k % NREQ));
      end
      tick(acc);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !==
          {1'b1, IDW'(k % NREQ), m_sum[WIDTH-1:0], m_sum[WIDTH]}) begin
        n_err++; $display("FAIL rr_rsp%0d: got v=%b id=%0d r=%h c=%b want v=1 id=%0d r=%h c=%b", k,
                          rsp_valid, rsp_id, rsp_result, rsp_cout, k % NREQ, m_sum[WIDTH-1:0], m_sum[WIDTH]);
      end
      if (rsp_valid) run++;
      op1[k % NREQ] = {$urandom, $urandom};
    end
    n_cmp++;
    if (run < 4) begin
      n_err++; $display("FAIL rr_stream: got %0d consecutive valid cycles want >= 4", run);
    end
    req_valid = '0;
    tick(acc);
  endtask

  task automatic test_backpressure();
    int acc;
    logic [WIDTH-1:0] held;
    do_reset();
    op1[0] = {$urandom, $urandom}; op2[0] = {$urandom, $urandom};
    op1[2] = {$urandom, $urandom}; op2[2] = {$urandom, $urandom}; req_cin = 4'b0100;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    tick(acc);
    held = m_sum[WIDTH-1:0];
    req_valid = 4'b0100; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== '0) begin
        n_err++; $display("FAIL bp_ready%0d: got %b want 0000", k, req_ready);
      end
      tick(acc);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, IDW'(0), held}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b id=%0d r=%h want v=1 id=0 r=%h",
                          k, rsp_valid, rsp_id, rsp_result, held);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release: got %b want 0100", req_ready);
    end
    tick(acc);
    req_valid = '0;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !==
        {1'b1, IDW'(2), op1[2] + op2[2] + 64'd1, m_sum[WIDTH]}) begin
      n_err++; $display("FAIL bp_replace: got v=%b id=%0d r=%h c=%b want v=1 id=2 r=%h",
                        rsp_valid, rsp_id, rsp_result, rsp_cout, op1[2] + op2[2] + 64'd1);
    end
    tick(acc);
  endtask

  task automatic test_carry();
    int acc;
    do_reset();
    op1[0] = 64'h7FFF_FFFF_FFFF_FFFF; op2[0] = 64'd0; req_cin = 4'b0001;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    tick(acc);
    req_valid = '0;
    n_cmp++;
    if ({rsp_result, rsp_cout} !== {64'h8000_0000_0000_0000, 1'b0}) begin
      n_err++; $display("FAIL carry: got r=%h c=%b want r=8000000000000000 c=0", rsp_result, rsp_cout);
    end
    tick(acc);
  endtask

  task automatic test_wrap_idle();
    int acc;
    do_reset();
    req_cin = '0; rsp_ready = 1'b1;
    req_valid = 4'b1000;
    tick(acc);
    req_valid = '0;
    tick(acc); tick(acc);
    req_valid = 4'b1010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL wrap_first: got %b want 0010", req_ready);
    end
    tick(acc);
    req_valid = 4'b1000;
    n_cmp++;
    if (rsp_id !== IDW'(1)) begin
      n_err++; $display("FAIL wrap_id1: got %0d want 1", rsp_id);
    end
    tick(acc);
    req_valid = '0;
    n_cmp++;
    if (rsp_id !== IDW'(3)) begin
      n_err++; $display("FAIL wrap_id3: got %0d want 3", rsp_id);
    end
    tick(acc);
  endtask

  task automatic test_reset_midop();
    int acc;
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0010;
    tick(acc);
    rst = 1'b1; req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++; $display("FAIL midrst_ready: got %b want 0000", req_ready);
    end
    tick(acc);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !== '0) begin
      n_err++; $display("FAIL midrst_rsp: got v=%b id=%0d r=%h c=%b want all zero",
                        rsp_valid, rsp_id, rsp_result, rsp_cout);
    end
    rst = 1'b0; req_valid = '1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL midrst_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick(acc);
  endtask

  task automatic test_random();
    int acc;
    int g;
    int others [NREQ];
    logic [WIDTH-1:0] e1, e2;
    logic             ec;
    do_reset();
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) others[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          req_valid[i] = 1'b1;
          op1[i] = ($urandom % 8 == 0) ? '1 : {$urandom, $urandom};
          op2[i] = {$urandom, $urandom};
          req_cin[i] = 1'($urandom);
          others[i] = 0;
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      #1;
      n_cmp++;
      if (req_ready !== exp_ready()) begin
        n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, exp_ready());
      end
      g = exp_grant();
      if ((!m_valid || rsp_ready) && g >= 0) begin
        e1 = op1[g]; e2 = op2[g]; ec = req_cin[g];
      end else begin
        e1 = op1[m_ptr]; e2 = op2[m_ptr]; ec = req_cin[m_ptr];
      end
      n_cmp++;
      if ({add_op1, add_op2, add_cin} !== {e1, e2, ec}) begin
        n_err++; $display("FAIL rnd_adder c%0d: got %h/%h/%b want %h/%h/%b",
                          cyc, add_op1, add_op2, add_cin, e1, e2, ec);
      end
      tick(acc);
      if (acc >= 0) begin
        n_cmp++;
        if (others[acc] > NREQ - 1) begin
          n_err++; $display("FAIL rnd_fair c%0d: req %0d waited %0d grants want <= %0d",
                            cyc, acc, others[acc], NREQ - 1);
        end
        for (int i = 0; i < NREQ; i++) if (i != acc && req_valid[i]) others[i]++;
        others[acc] = 0;
        req_valid[acc] = 1'b0;
      end
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_cout} !==
          {m_valid, IDW'(m_id), m_sum[WIDTH-1:0], m_sum[WIDTH]}) begin
        n_err++; $display("FAIL rnd_rsp c%0d: got v=%b id=%0d r=%h c=%b want v=%b id=%0d r=%h c=%b", cyc,
                          rsp_valid, rsp_id, rsp_result, rsp_cout,
                          m_valid, m_id, m_sum[WIDTH-1:0], m_sum[WIDTH]);
      end
    end
    req_valid = '0;
    tick(acc);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_cin = '0;
    m_ptr = 0; m_valid = 0; m_id = 0; m_sum = '0;
    for (int i = 0; i < NREQ; i++) begin op1[i] = '0; op2[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_carry();
    test_wrap_idle();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
